// File: rtl/dr_pkg.sv
// Shared constants and entry layout for the prioritised data register.
package dr_pkg;

  localparam int SRC_INSM = 0;
  localparam int SRC_DM   = 1;
  localparam int SRC_BUS  = 2;

  localparam int DR_WIDTH = 12;
  localparam int DR_ID_W  = 2;

  typedef struct packed {
    logic [DR_ID_W-1:0]  src_id;
    logic [DR_WIDTH-1:0] data;
  } dr_entry_t;

endpackage

// File: rtl/dr_pend_fifo.sv
// Synchronous FIFO holding deferred writes; flush empties it in one cycle.
module dr_pend_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dr_prio_queue.sv
// Fixed-priority data register; the losing runner-up write is deferred to
// a pending FIFO and committed on a later idle cycle.
module dr_prio_queue
  import dr_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NSRC  = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NSRC-1:0]            wr_en,
  input  logic [NSRC*WIDTH-1:0]      wr_data,
  input  logic                       flush,
  input  logic                       clear_flags,
  output logic [WIDTH-1:0]           dataout,
  output logic [$clog2(NSRC)-1:0]    src_id,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       collision,
  output logic                       drop
);

  localparam int ID_W = $clog2(NSRC);
  localparam int CW   = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ID_W-1:0]  src_id;
    logic [WIDTH-1:0] data;
  } entry_t;

  function automatic logic [ID_W-1:0] first_set(input logic [NSRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Second set bit: clear the first one and search again.
  function automatic logic [ID_W-1:0] second_set(input logic [NSRC-1:0] v);
    logic [NSRC-1:0] m;
    m = v;
    m[first_set(v)] = 1'b0;
    return first_set(m);
  endfunction

  function automatic int popcount(input logic [NSRC-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NSRC; i++) n += int'(v[i]);
    return n;
  endfunction

  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic [ID_W-1:0]  src_id_q, src_id_d;
  logic             collision_q, collision_d;
  logic             drop_q, drop_d;

  logic [ID_W-1:0]  win_idx, run_idx;
  logic             any_wr, multi_wr, over_wr;
  logic             push, pop, fifo_full, fifo_empty;
  logic             drop_evt;
  entry_t           push_entry, head_entry;
  logic [CW-1:0]    fifo_count;

  assign win_idx  = first_set(wr_en);
  assign run_idx  = second_set(wr_en);
  assign any_wr   = |wr_en;
  assign multi_wr = popcount(wr_en) >= 2;
  assign over_wr  = popcount(wr_en) >= 3;

  assign push     = multi_wr && !flush && !fifo_full;
  assign pop      = !any_wr && !fifo_empty && !flush;
  assign drop_evt = over_wr || (multi_wr && (flush || fifo_full));

  assign push_entry.src_id = run_idx;
  assign push_entry.data   = wr_data[run_idx*WIDTH +: WIDTH];

  dr_pend_fifo #(
    .W     (ID_W + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    dataout_d = dataout_q;
    src_id_d  = src_id_q;
    if (any_wr) begin
      dataout_d = wr_data[win_idx*WIDTH +: WIDTH];
      src_id_d  = win_idx;
    end else if (pop) begin
      dataout_d = head_entry.data;
      src_id_d  = head_entry.src_id;
    end
    collision_d = multi_wr || (collision_q && !clear_flags);
    drop_d      = drop_evt || (drop_q && !clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q   <= '0;
      src_id_q    <= ID_W'(SRC_INSM);
      collision_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      dataout_q   <= dataout_d;
      src_id_q    <= src_id_d;
      collision_q <= collision_d;
      drop_q      <= drop_d;
    end
  end

  assign dataout   = dataout_q;
  assign src_id    = src_id_q;
  assign pending   = fifo_count;
  assign collision = collision_q;
  assign drop      = drop_q;

endmodule
